// File: rtl/parity_pkg.sv
// Shared constants and helper for the parity frame generator.
package parity_pkg;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    // Widest word par_bit accepts; narrower callers zero-extend, which leaves the XOR unchanged.
    localparam int   PAR_MAX_W = 256;

    function automatic logic par_bit(input logic [PAR_MAX_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational parity of one word: raw XOR reduction and mode-adjusted parity bit.
module parity_calc
    import parity_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_odd,
    output logic             o_raw,
    output logic             o_par
);

    assign o_raw = ^i_data;

    generate
        if (WIDTH <= PAR_MAX_W) begin : g_fn
            assign o_par = par_bit(PAR_MAX_W'(i_data), i_odd);
        end else begin : g_wide
            assign o_par = o_raw ^ i_odd;
        end
    endgenerate

endmodule

// File: rtl/parity_frame_gen.sv
// Streaming parity generator: one register stage, per-word parity and per-frame parity on the last word.
module parity_frame_gen
    import parity_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             odd_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_word_par,
    output logic             out_last,
    output logic             out_frame_par
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_word_par;
    logic             r_last;
    logic             r_frame_par;
    logic             r_acc;
    logic [CNT_W-1:0] r_idx;

    logic             w_accept;
    logic             w_raw;
    logic             w_word_par;
    logic             w_acc_next;
    logic             w_is_last;

    parity_calc #(
        .WIDTH (WIDTH)
    ) u_word_par (
        .i_data (in_data),
        .i_odd  (odd_mode),
        .o_raw  (w_raw),
        .o_par  (w_word_par)
    );

    // Ready only depends on the output stage, so no in_valid -> in_ready path exists.
    assign in_ready   = !r_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_acc_next = r_acc ^ w_raw;
    assign w_is_last  = (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_word_par  <= 1'b0;
            r_last      <= 1'b0;
            r_frame_par <= 1'b0;
            r_acc       <= 1'b0;
            r_idx       <= '0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_data     <= in_data;
            r_word_par <= w_word_par;
            if (w_is_last) begin
                r_last      <= 1'b1;
                r_frame_par <= w_acc_next ^ odd_mode;
                r_acc       <= 1'b0;
                r_idx       <= '0;
            end else begin
                r_last      <= 1'b0;
                r_frame_par <= 1'b0;
                r_acc       <= w_acc_next;
                r_idx       <= r_idx + CNT_W'(1);
            end
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid     = r_valid;
    assign out_data      = r_data;
    assign out_word_par  = r_word_par;
    assign out_last      = r_last;
    assign out_frame_par = r_frame_par;

endmodule

// File: tb/tb_parity_frame_gen.sv
// Scoreboard bench for parity_frame_gen with directed, hand-computed vectors (WIDTH=8, FRAME_LEN=4).
module tb_parity_frame_gen;

    localparam int WIDTH     = 8;
    localparam int FRAME_LEN = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       wp;
        logic       l;
        logic       fp;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             odd_mode = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic             out_word_par;
    logic             out_last;
    logic             out_frame_par;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    parity_frame_gen #(
        .WIDTH     (WIDTH),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .odd_mode      (odd_mode),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_word_par  (out_word_par),
        .out_last      (out_last),
        .out_frame_par (out_frame_par)
    );

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endfunction

    // Monitor: a transfer completes at the next rising edge whenever valid and ready are both high here.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got data 0x%0h, expected no output", out_data);
                end else begin
                    e = sb.pop_front();
                    $display("xfer data=0x%02h wpar=%0d last=%0d fpar=%0d (exp 0x%02h %0d %0d %0d)",
                             out_data, out_word_par, out_last, out_frame_par, e.d, e.wp, e.l, e.fp);
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("out_word_par", 32'(out_word_par), 32'(e.wp));
                    chk("out_last", 32'(out_last), 32'(e.l));
                    chk("out_frame_par", 32'(out_frame_par), 32'(e.fp));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge, leaving in_valid high.
    task automatic send(input logic [7:0] d, input logic odd, input logic wp, input logic l, input logic fp);
        int   waited;
        exp_t e;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        odd_mode = odd;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) begin
                n_checks++;
                $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected 1 (data 0x%02h)", d);
                in_valid = 1'b0;
                return;
            end
        end
        e.d  = d;
        e.wp = wp;
        e.l  = l;
        e.fp = fp;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d pending words, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no $finish by 200000, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] wp6;
        wp6 = 8'b1001_0110;

        // 1. Reset, then asynchronous mid-cycle reset with a held word
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_out_last", 32'(out_last), 32'd0);
        chk("post_rst_out_frame_par", 32'(out_frame_par), 32'd0);
        chk("post_rst_out_data", 32'(out_data), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(8'h54, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("held_out_valid", 32'(out_valid), 32'd1);
        chk("held_in_ready", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out_data", 32'(out_data), 32'd0);
        chk("async_rst_out_word_par", 32'(out_word_par), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // 2. Word parity; the 4th word closes frame: 4+3+4+3 ones = even, odd mode -> fpar 1
        send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
        send(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        send(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
        idle();
        wait_drain();

        // 3. Frame parity, even then odd on the last word (10 ones)
        send(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
        send(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
        send(8'h0F, 1'b1, 1'b1, 1'b1, 1'b1);
        idle();
        wait_drain();

        // 4. Backpressure: 80 held for 3 cycles, 81 waits, then 82/83 complete the frame (8 ones)
        send(8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h81;
        odd_mode  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data", 32'(out_data), 32'h80);
            chk("bp_out_word_par", 32'(out_word_par), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h82, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h83, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        wait_drain();

        // 5. Reset mid-frame, then a fresh frame of FF x4 (32 ones)
        send(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        wait_drain();
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        wait_drain();

        // 6. Full throughput: 00..07 back to back
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(8'(i), 1'b0, wp6[i], (i == 3 || i == 7), 1'b0);
                idle();
            end
            begin
                int w;
                int cnt;
                w   = 0;
                cnt = 0;
                while (!out_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                for (int k = 0; k < 8; k++) begin
                    if (out_valid) cnt++;
                    @(negedge clk);
                end
                chk("throughput_valid_run", 32'(cnt), 32'd8);
            end
        join
        wait_drain();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
